// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reaction_pkg;

    // Round controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_GO      = 3'd2,
        ST_RESULT  = 3'd3,
        ST_FOUL    = 3'd4,
        ST_SUMMARY = 3'd5
    } round_state_t;

    // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    // Tap mask selects register bits 15, 13, 12 and 10 for the feedback XOR.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Reaction time type for the default 4095 ms saturation value
    localparam int MAX_MS_DEFAULT = 4095;
    typedef logic [$clog2(MAX_MS_DEFAULT+1)-1:0] reaction_ms_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low OUT_W bits.
// Latency: one step per enabled clk cycle.
// Backpressure: none; en_i gates the shift.
// Ports: clk, reset (async active-high), en_i (advance), lfsr_o (low OUT_W bits of state).
module lfsr16
    import reaction_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift left, feedback into bit 0 is the parity of the tapped bits
    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_round_sequencer.sv
// Multi-round reaction-time match controller: random arm delay, LED, ms timing, foul detect, best time.
// Latency: every transition lands on the clk edge after its trigger; outputs are registered from next state.
// Backpressure: none; play and ms_tick are single-cycle pulses, play is ignored in RESULT/FOUL.
// Ports: clk, reset (async active-high), ms_tick, play in; led_on, display_enable, display_value,
//        false_start, round_done, round_idx, best_ms out.
module reaction_round_sequencer
    import reaction_pkg::*;
#(
    parameter int  MAX_MS         = 4095,
    parameter int  MIN_DELAY_MS   = 1000,
    parameter int  DELAY_SPAN_MS  = 2048,
    parameter int  RESULT_HOLD_MS = 3000,
    parameter int  ROUNDS         = 5,
    localparam int W              = $clog2(MAX_MS+1),
    localparam int R              = $clog2(ROUNDS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_tick,
    input  logic         play,
    output logic         led_on,
    output logic         display_enable,
    output logic [W-1:0] display_value,
    output logic         false_start,
    output logic         round_done,
    output logic [R-1:0] round_idx,
    output logic [W-1:0] best_ms
);

    localparam int DW = $clog2(MIN_DELAY_MS + DELAY_SPAN_MS);  // holds MIN+SPAN-1
    localparam int SW = $clog2(DELAY_SPAN_MS);
    localparam int HW = $clog2(RESULT_HOLD_MS + 1);

    localparam logic [W-1:0]  MAX_V      = W'(MAX_MS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESULT_HOLD_MS - 1);
    localparam logic [R-1:0]  ROUND_LAST = R'(ROUNDS - 1);

    logic [SW-1:0] lfsr_low;
    logic [DW-1:0] new_delay;

    round_state_t  state_q,   state_d;
    logic [DW-1:0] delay_q,   delay_d;
    logic [W-1:0]  react_q,   react_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic [R-1:0]  round_q,   round_d;
    logic [W-1:0]  latched_q, latched_d;
    logic [W-1:0]  best_q,    best_d;
    logic          done_d;

    logic          led_q,  led_d;
    logic          den_q,  den_d;
    logic [W-1:0]  dval_q, dval_d;
    logic          foul_q, foul_d;
    logic          done_q;

    lfsr16 #(
        .OUT_W (SW)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (1'b1),
        .lfsr_o (lfsr_low)
    );

    // Delay is sampled from the LFSR in the same cycle the ARM transition is taken
    assign new_delay = DW'(MIN_DELAY_MS) + DW'(lfsr_low);

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        react_d   = react_q;
        hold_d    = hold_q;
        round_d   = round_q;
        latched_d = latched_q;
        best_d    = best_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    state_d = ST_ARM;
                    round_d = '0;
                    delay_d = new_delay;
                end
            end
            ST_ARM: begin
                // A press always wins over a tick arriving in the same cycle
                if (play) begin
                    state_d = ST_FOUL;
                    hold_d  = '0;
                end else if (ms_tick) begin
                    if (delay_q == '0) begin
                        state_d = ST_GO;
                        react_d = '0;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end
            end
            ST_GO: begin
                // On a same-cycle press the pending tick is not counted
                if (play) begin
                    state_d   = ST_RESULT;
                    latched_d = react_q;
                    hold_d    = '0;
                    done_d    = 1'b1;
                end else if (ms_tick) begin
                    if (react_q == MAX_V) begin
                        state_d   = ST_RESULT;
                        latched_d = MAX_V;
                        hold_d    = '0;
                        done_d    = 1'b1;
                    end else begin
                        react_d = react_q + 1'b1;
                    end
                end
                if (done_d && (latched_d < best_q)) begin
                    best_d = latched_d;
                end
            end
            ST_RESULT: begin
                if (ms_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (round_q == ROUND_LAST) begin
                            state_d = ST_SUMMARY;
                        end else begin
                            state_d = ST_ARM;
                            round_d = round_q + 1'b1;
                            delay_d = new_delay;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_FOUL: begin
                // Round is replayed: round index untouched
                if (ms_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = ST_ARM;
                        delay_d = new_delay;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_SUMMARY: begin
                if (play) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore decode applied to the next state so the registered outputs track the state register
    always_comb begin
        led_d  = (state_d == ST_GO);
        den_d  = (state_d != ST_IDLE) && (state_d != ST_ARM);
        foul_d = (state_d == ST_FOUL);
        case (state_d)
            ST_GO:      dval_d = react_d;
            ST_RESULT:  dval_d = latched_d;
            ST_SUMMARY: dval_d = best_d;
            default:    dval_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            react_q   <= '0;
            hold_q    <= '0;
            round_q   <= '0;
            latched_q <= '0;
            best_q    <= MAX_V;
            led_q     <= 1'b0;
            den_q     <= 1'b0;
            dval_q    <= '0;
            foul_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            react_q   <= react_d;
            hold_q    <= hold_d;
            round_q   <= round_d;
            latched_q <= latched_d;
            best_q    <= best_d;
            led_q     <= led_d;
            den_q     <= den_d;
            dval_q    <= dval_d;
            foul_q    <= foul_d;
            done_q    <= done_d;
        end
    end

    assign led_on         = led_q;
    assign display_enable = den_q;
    assign display_value  = dval_q;
    assign false_start    = foul_q;
    assign round_done     = done_q;
    assign round_idx      = round_q;
    assign best_ms        = best_q;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Directed bench for reaction_round_sequencer with small parameters and a 1-in-4 ms_tick.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_reaction_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ms_tick;
    logic       play;
    logic       led_on;
    logic       display_enable;
    logic [3:0] display_value;
    logic       false_start;
    logic       round_done;
    logic [0:0] round_idx;
    logic [3:0] best_ms;

    int          n_cmp = 0;
    int          n_err = 0;
    int          phase = 0;
    int          rd_cnt = 0;
    bit          tick_last = 1'b0;
    logic [15:0] m;
    logic [15:0] m_at;

    reaction_round_sequencer #(
        .MAX_MS         (15),
        .MIN_DELAY_MS   (4),
        .DELAY_SPAN_MS  (4),
        .RESULT_HOLD_MS (3),
        .ROUNDS         (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ms_tick        (ms_tick),
        .play           (play),
        .led_on         (led_on),
        .display_enable (display_enable),
        .display_value  (display_value),
        .false_start    (false_start),
        .round_done     (round_done),
        .round_idx      (round_idx),
        .best_ms        (best_ms)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One clk cycle: tick on every 4th cycle, optional play pulse
    task automatic cycle(input bit p);
        ms_tick = (phase == 3);
        play    = p;
        m_at    = m;
        @(posedge clk);
        if (reset) m = 16'hACE1;
        else       m = lfsr_step(m);
        tick_last = ms_tick;
        phase     = (phase + 1) % 4;
        #1;
        ms_tick = 1'b0;
        play    = 1'b0;
        if (round_done) rd_cnt++;
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < n * 4 + 8 && seen < n; c++) begin
            cycle(1'b0);
            if (tick_last) seen++;
        end
        if (seen < n) check_eq("tick_budget", seen, n);
    endtask

    // Run through ARM until the LED lights; returns ticks seen in ARM
    task automatic wait_go(output int ticks);
        ticks = 0;
        for (int c = 0; c < 200 && !led_on; c++) begin
            cycle(1'b0);
            if (tick_last) ticks++;
        end
        if (!led_on) check_eq("go_timeout", 0, 1);
    endtask

    task automatic play_round(input int n, input int best_exp, input string tag);
        int t;
        wait_go(t);
        run_ticks(n);
        cycle(1'b1);
        check_eq({tag, "_val"},  display_value, n);
        check_eq({tag, "_done"}, round_done, 1);
        check_eq({tag, "_best"}, best_ms, best_exp);
        cycle(1'b0);
        check_eq({tag, "_done1"}, round_done, 0);
        run_ticks(3);
    endtask

    initial begin
        int d_exp;
        int t;
        int rd0;
        reset   = 1'b1;
        ms_tick = 1'b0;
        play    = 1'b0;
        m       = 16'hACE1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_led",  led_on, 0);
        check_eq("rst_den",  display_enable, 0);
        check_eq("rst_val",  display_value, 0);
        check_eq("rst_fs",   false_start, 0);
        check_eq("rst_rd",   round_done, 0);
        check_eq("rst_idx",  round_idx, 0);
        check_eq("rst_best", best_ms, 15);
        reset = 1'b0;
        m     = 16'hACE1;
        cycle(1'b0);
        cycle(1'b0);

        // Arm delay: D+1 ticks, LED the cycle after the last one
        cycle(1'b1);
        d_exp = 4 + int'(m_at[1:0]);
        check_eq("arm_den", display_enable, 0);
        wait_go(t);
        check_eq("arm_ticks", t, d_exp + 1);
        check_eq("arm_led_after_tick", tick_last, 1);
        check_eq("go_den", display_enable, 1);

        // Normal round of 5, play ignored during RESULT
        run_ticks(5);
        check_eq("go_live", display_value, 5);
        cycle(1'b1);
        check_eq("r5_val",  display_value, 5);
        check_eq("r5_done", round_done, 1);
        check_eq("r5_best", best_ms, 5);
        check_eq("r5_led",  led_on, 0);
        cycle(1'b1);
        check_eq("r5_done1", round_done, 0);
        check_eq("r5_ignore", display_value, 5);
        run_ticks(2);
        check_eq("r5_idx_hold", round_idx, 0);
        run_ticks(1);
        check_eq("r5_idx_next", round_idx, 1);
        check_eq("r5_arm_den", display_enable, 0);

        // False start: held 3 ticks, then ARM again on the same round
        rd0 = rd_cnt;
        cycle(1'b1);
        check_eq("foul_fs",  false_start, 1);
        check_eq("foul_val", display_value, 0);
        check_eq("foul_den", display_enable, 1);
        run_ticks(2);
        check_eq("foul_hold", false_start, 1);
        run_ticks(1);
        check_eq("foul_end",  false_start, 0);
        check_eq("foul_arm",  display_enable, 0);
        check_eq("foul_idx",  round_idx, 1);
        check_eq("foul_nord", rd_cnt, rd0);

        // Timeout on the last round of match 1
        wait_go(t);
        run_ticks(15);
        check_eq("tmo_live", display_value, 15);
        check_eq("tmo_led",  led_on, 1);
        run_ticks(1);
        check_eq("tmo_val",  display_value, 15);
        check_eq("tmo_done", round_done, 1);
        check_eq("tmo_best", best_ms, 5);
        run_ticks(3);
        check_eq("sum1_val", display_value, 5);
        check_eq("sum1_den", display_enable, 1);
        cycle(1'b1);
        check_eq("idle1_den", display_enable, 0);

        // Match 2: rounds of 7 then 3
        cycle(1'b1);
        check_eq("m2_idx", round_idx, 0);
        play_round(7, 5, "m2r0");
        play_round(3, 3, "m2r1");
        check_eq("sum2_val", display_value, 3);
        cycle(1'b1);
        check_eq("idle2_val",  display_value, 0);
        check_eq("idle2_best", best_ms, 3);

        // Match 3: round of 9, then a press coincident with the 7th tick
        cycle(1'b1);
        play_round(9, 3, "m3r0");
        wait_go(t);
        run_ticks(6);
        while (phase != 3) cycle(1'b0);
        cycle(1'b1);
        check_eq("same_val",  display_value, 6);
        check_eq("same_done", round_done, 1);
        check_eq("same_best", best_ms, 3);
        run_ticks(4);
        check_eq("sum3_val", display_value, 3);
        cycle(1'b1);

        // Match 4: reset while the LED is lit
        cycle(1'b1);
        wait_go(t);
        run_ticks(2);
        check_eq("pre_rst_led", led_on, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_led",  led_on, 0);
        check_eq("mid_den",  display_enable, 0);
        check_eq("mid_val",  display_value, 0);
        check_eq("mid_fs",   false_start, 0);
        check_eq("mid_rd",   round_done, 0);
        check_eq("mid_idx",  round_idx, 0);
        check_eq("mid_best", best_ms, 15);
        cycle(1'b0);
        reset = 1'b0;
        m     = 16'hACE1;
        cycle(1'b0);
        check_eq("post_den",  display_enable, 0);
        check_eq("post_best", best_ms, 15);
        cycle(1'b1);
        check_eq("post_arm_led", led_on, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_round_sequencer.md
# reaction_round_sequencer

Top-level round controller for the reaction-time game. It runs a multi-round match:
- generates a pseudo-random arm delay;
- lights the LED;
- measures the player's reaction in milliseconds;
- detects false starts;
- holds each result on the display;
- tracks the best time over the match.

It sits between the debounced button / ms-tick generator and the LED and seven-segment display driver.

## Interface
Parameters:
- MAX_MS, 4095: reaction counter saturation value (timeout).
- MIN_DELAY_MS, 1000: minimum arm delay in ms.
- DELAY_SPAN_MS, 2048: random delay span; must be a power of 2.
- RESULT_HOLD_MS, 3000: result/foul display hold time in ms.
- ROUNDS, 5: scored rounds per match.

Ports (W = $clog2(MAX_MS+1), R = $clog2(ROUNDS)):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ms_tick  in  1  one-cycle pulse per millisecond
- play  in  1  one-cycle debounced button press pulse
- led_on  out  1  "react now" LED
- display_enable  out  1  display driver enable
- display_value  out  W  value shown on the display, in ms
- false_start  out  1  high while in FOUL
- round_done  out  1  one-cycle pulse when a scored result is latched
- round_idx  out  R  current round, 0-based
- best_ms  out  W  best reaction time this match

## Operation
**States:** IDLE, ARM, GO, RESULT, FOUL, SUMMARY.
- **IDLE:** play → ARM; clear round_idx; load the delay.
- **ARM:** each ms_tick decrements delay_cnt.
  - ms_tick with delay_cnt==0 → GO.
  - play → FOUL. play has priority over a same-cycle tick.
- **GO:** react_cnt is cleared on entry and increments on ms_tick, saturating at MAX_MS.
  - play → RESULT, latching react_cnt. The latched value excludes a same-cycle tick.
  - ms_tick with react_cnt==MAX_MS → RESULT, latching MAX_MS.
- **RESULT:** round_done pulses in the entry cycle. If latched < best_ms, best_ms takes latched in that cycle.
  - hold_cnt counts RESULT_HOLD_MS ticks, then:
    - round_idx==ROUNDS-1 → SUMMARY;
    - otherwise round_idx+1 → ARM with a new delay.
  - play is ignored.
- **FOUL:** hold RESULT_HOLD_MS ticks, then → ARM with a new delay. round_idx is unchanged (the round is replayed). play is ignored.
- **SUMMARY:** play → IDLE. best_ms is retained until reset.

**Delay generation:**
- Delay = MIN_DELAY_MS + lfsr[$clog2(DELAY_SPAN_MS)-1:0], sampled in the cycle the ARM transition is taken.
- lfsr is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1. It advances every clk cycle, so human timing supplies the entropy.

**Output decode** (Moore, from the state register):

| State | led_on | display_enable | display_value | false_start |
|---|---|---|---|---|
| IDLE | 0 | 0 | 0 | 0 |
| ARM | 0 | 0 | 0 | 0 |
| GO | 1 | 1 | live react_cnt | 0 |
| RESULT | 0 | 1 | latched time | 0 |
| FOUL | 0 | 1 | 0 | 1 |
| SUMMARY | 0 | 1 | best_ms | 0 |

**Width rules:**
- delay_cnt is wide enough for MIN_DELAY_MS+DELAY_SPAN_MS-1.
- All counters saturate; none wrap.

## Timing
**Reset values** (asynchronous; outputs take these immediately, including mid-round):
- state IDLE;
- led_on, display_enable, false_start, round_done: 0;
- display_value 0, round_idx 0;
- best_ms MAX_MS;
- lfsr 16'hACE1;
- all counters 0.

**Latency:**
- Every state transition takes effect at the clk edge after its trigger, and outputs follow that edge.
- Arm delay D means D+1 ms_ticks in ARM.
- round_done is high exactly one cycle, coincident with the first RESULT cycle.

**Input assumptions:** play and ms_tick are synchronous to clk and never wider than one cycle.

## Structure
**Shared package** reaction_pkg:
- state enum round_state_t;
- LFSR seed and tap constants;
- a reaction_ms_t typedef sized from MAX_MS.

**Sub-module** lfsr16: free-running LFSR with enable and async reset. Its taps and seed come from the package.

## Test plan
All tests use MAX_MS=15, MIN_DELAY_MS=4, DELAY_SPAN_MS=4, RESULT_HOLD_MS=3, ROUNDS=2, with ms_tick every 4 clk. The bench models the LFSR.

1. **Arm delay:** play in IDLE → number of ARM ticks equals 4+lfsr[1:0]+1 at the play cycle; led_on rises one cycle after the final tick.
2. **Normal round:** press play after 5 GO ticks → display_value=5, best_ms=5, round_done one cycle, round_idx→1 after 3 hold ticks.
3. **False start:** play during ARM → false_start=1 and display_value=0 for 3 ticks, then ARM with round_idx unchanged; no round_done.
4. **Timeout and same-cycle press:**
   - no press in GO → RESULT with display_value=15 after the 16th tick;
   - play coincident with a tick at react_cnt 6 → latched 6.
5. **Full match:** rounds of 7 then 3 → SUMMARY with display_value=3; play → IDLE; best_ms still 3; a following round of 9 leaves best_ms=3.
6. **Reset mid-operation:** assert reset mid-GO (led_on=1) → all outputs at reset values before the next clk edge; on release, state IDLE and best_ms=15.
